// File: rtl/aes32_state_ctrl_if.sv
// Handshake, key/randomness availability and datapath control bundle for aes32_state_ctrl.
// With SMAESH_CTRL_ABORT_EN defined the bundle also carries the abort request.
interface aes32_state_ctrl_if;
`ifdef SMAESH_CTRL_ABORT_EN
  logic abort;
`endif
  logic in_valid;
  logic in_inverse;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic rk_valid;
  logic rk_next;
  logic rnd_valid;
  logic sbox_en;
  logic sbox_valid_in;
  logic enable;
  logic init;
  logic en_MC;
  logic en_loop;
  logic en_loop_r0;
  logic en_SB_inverse;
  logic bypass_MC_inverse;
  logic en_toSB_inverse;

  modport master (
`ifdef SMAESH_CTRL_ABORT_EN
    output abort,
`endif
    output in_valid, in_inverse, out_ready, rk_valid, rnd_valid,
    input  in_ready, out_valid, rk_next, sbox_en, sbox_valid_in, enable, init,
    input  en_MC, en_loop, en_loop_r0, en_SB_inverse, bypass_MC_inverse, en_toSB_inverse
  );

  modport slave (
`ifdef SMAESH_CTRL_ABORT_EN
    input  abort,
`endif
    input  in_valid, in_inverse, out_ready, rk_valid, rnd_valid,
    output in_ready, out_valid, rk_next, sbox_en, sbox_valid_in, enable, init,
    output en_MC, en_loop, en_loop_r0, en_SB_inverse, bypass_MC_inverse, en_toSB_inverse
  );
endinterface

// File: rtl/aes32_state_ctrl.sv
// Sequencing controller for the 32-bit serial masked AES state datapath.
// Optional macro SMAESH_CTRL_ABORT_EN adds an abort input that returns the controller to IDLE.
module aes32_state_ctrl #(
  parameter int unsigned SBOX_LAT = 4,
  parameter int unsigned NR       = 10
) (
  input logic               clk,
  input logic               rst_n,
  aes32_state_ctrl_if.slave bus
);

  localparam int unsigned CYC_W = $clog2(SBOX_LAT + 4);
  localparam int unsigned RND_W = $clog2(NR);
  localparam logic [CYC_W-1:0] FEED_END = CYC_W'(4);
  localparam logic [CYC_W-1:0] WB_START = CYC_W'(SBOX_LAT);
  localparam logic [CYC_W-1:0] RND_END  = CYC_W'(SBOX_LAT + 3);
  localparam logic [CYC_W-1:0] FIN_END  = CYC_W'(3);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             inverse_q, inverse_d;
`ifdef SMAESH_CTRL_ABORT_EN
  logic             rewind_q, rewind_d;
`endif

  logic feed_c, wb_c, stall_c;
  logic in_ready_c, out_valid_c, rk_next_c, sbox_en_c, sbox_valid_in_c;
  logic enable_c, init_c, en_mc_c, en_loop_c, en_loop_r0_c;
  logic en_sb_inv_c, bypass_mc_inv_c, en_tosb_inv_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      round_q   <= '0;
      inverse_q <= 1'b0;
`ifdef SMAESH_CTRL_ABORT_EN
      rewind_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      round_q   <= round_d;
      inverse_q <= inverse_d;
`ifdef SMAESH_CTRL_ABORT_EN
      rewind_q  <= rewind_d;
`endif
    end
  end

  // Routing selects follow state/cyc/round only, so they hold naturally while stalled.
  always_comb begin
    state_d         = state_q;
    cyc_d           = cyc_q;
    round_d         = round_q;
    inverse_d       = inverse_q;
    in_ready_c      = 1'b0;
    out_valid_c     = 1'b0;
    rk_next_c       = 1'b0;
    sbox_en_c       = 1'b0;
    sbox_valid_in_c = 1'b0;
    enable_c        = 1'b0;
    init_c          = 1'b0;
    en_mc_c         = 1'b0;
    en_loop_c       = 1'b0;
    en_loop_r0_c    = 1'b0;
    en_sb_inv_c     = 1'b0;
    bypass_mc_inv_c = 1'b0;
    en_tosb_inv_c   = 1'b0;
`ifdef SMAESH_CTRL_ABORT_EN
    rewind_d        = 1'b0;
`endif
    feed_c  = (state_q == ST_ROUND) && (cyc_q < FEED_END);
    wb_c    = (state_q == ST_ROUND) && (cyc_q >= WB_START);
    stall_c = ((feed_c || (state_q == ST_FINAL)) && !bus.rk_valid) ||
              ((state_q == ST_ROUND) && !bus.rnd_valid);

    case (state_q)
      ST_IDLE: begin
        in_ready_c = 1'b1;
`ifdef SMAESH_CTRL_ABORT_EN
        rk_next_c  = rewind_q;
`endif
        if (bus.in_valid) begin
          init_c    = 1'b1;
          enable_c  = 1'b1;
          inverse_d = bus.in_inverse;
          round_d   = '0;
          cyc_d     = '0;
          state_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        en_mc_c         = !inverse_q && (round_q != LAST_RND);
        en_tosb_inv_c   = inverse_q;
        en_sb_inv_c     = inverse_q && wb_c;
        en_loop_c       = inverse_q && feed_c;
        bypass_mc_inv_c = inverse_q && (round_q == '0);
        if (!stall_c) begin
          sbox_en_c       = 1'b1;
          sbox_valid_in_c = feed_c;
          enable_c        = feed_c || wb_c;
          if (cyc_q == RND_END) begin
            rk_next_c = 1'b1;
            cyc_d     = '0;
            if (round_q == LAST_RND) state_d = ST_FINAL;
            else                     round_d = round_q + RND_W'(1);
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
      end
      ST_FINAL: begin
        en_loop_r0_c = 1'b1;
        if (!stall_c) begin
          sbox_en_c = 1'b1;
          enable_c  = 1'b1;
          if (cyc_q == FIN_END) begin
            rk_next_c = 1'b1;
            cyc_d     = '0;
            state_d   = ST_DONE;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
      end
      ST_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef SMAESH_CTRL_ABORT_EN
    // Abort drops the operation; the rewind pulse is emitted from IDLE next cycle.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d         = ST_IDLE;
      cyc_d           = '0;
      round_d         = '0;
      inverse_d       = 1'b0;
      rewind_d        = 1'b1;
      out_valid_c     = 1'b0;
      rk_next_c       = 1'b0;
      sbox_en_c       = 1'b0;
      sbox_valid_in_c = 1'b0;
      enable_c        = 1'b0;
      en_mc_c         = 1'b0;
      en_loop_c       = 1'b0;
      en_loop_r0_c    = 1'b0;
      en_sb_inv_c     = 1'b0;
      bypass_mc_inv_c = 1'b0;
      en_tosb_inv_c   = 1'b0;
    end
`endif
  end

  assign bus.in_ready          = in_ready_c;
  assign bus.out_valid         = out_valid_c;
  assign bus.rk_next           = rk_next_c;
  assign bus.sbox_en           = sbox_en_c;
  assign bus.sbox_valid_in     = sbox_valid_in_c;
  assign bus.enable            = enable_c;
  assign bus.init              = init_c;
  assign bus.en_MC             = en_mc_c;
  assign bus.en_loop           = en_loop_c;
  assign bus.en_loop_r0        = en_loop_r0_c;
  assign bus.en_SB_inverse     = en_sb_inv_c;
  assign bus.bypass_MC_inverse = bypass_mc_inv_c;
  assign bus.en_toSB_inverse   = en_tosb_inv_c;

endmodule

// File: tb/tb_aes32_state_ctrl.sv
// Self-checking bench for aes32_state_ctrl (SBOX_LAT=4, NR=10); cycle 0 is the acceptance cycle.
// Define SMAESH_CTRL_ABORT_EN to also exercise the abort path.
module tb_aes32_state_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  aes32_state_ctrl_if bus ();

  aes32_state_ctrl #(.SBOX_LAT(4), .NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int exp_lat;
  int ov_first, ov_cnt, rk_cnt, en_err, en_lo, sb_lo, mc0_cnt, mc0_first, mc0_last, mc1_cnt;
  int byp_cnt, byp_first, byp_last, tosb_cnt, loop_cnt, sbinv_cnt, r0_cnt, rdy_busy, done_en, ir_after;
  int ab_ir0, ab_ir1, ab_rk1;

  logic [12:0] outs;
  assign outs = {bus.in_ready, bus.out_valid, bus.rk_next, bus.sbox_en, bus.sbox_valid_in,
                 bus.enable, bus.init, bus.en_MC, bus.en_loop, bus.en_loop_r0,
                 bus.en_SB_inverse, bus.bypass_MC_inverse, bus.en_toSB_inverse};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input int c, input int at, input int len);
    return (c >= at) && (c < at + len);
  endfunction

  // One operation: windows of missing randomness / key (stalling), one non-stalling key gap,
  // out_ready held low for 'hold' DONE cycles, optional reset or abort at a given cycle.
  task automatic run_txn(input bit inv, input int rnd_at, input int rnd_len,
                         input int rkf_at, input int rkf_len, input int rkn_at,
                         input int hold, input int rst_at, input int abort_at,
                         input int lat, input int max_cyc);
    bit busy;
    bit stall;
    ov_first = -1; ov_cnt = 0; rk_cnt = 0; en_err = 0; en_lo = 0; sb_lo = 0;
    mc0_cnt = 0; mc0_first = -1; mc0_last = -1; mc1_cnt = 0;
    byp_cnt = 0; byp_first = -1; byp_last = -1; tosb_cnt = 0; loop_cnt = 0; sbinv_cnt = 0;
    r0_cnt = 0; rdy_busy = 0; done_en = 0; ir_after = -1; ab_ir0 = -1; ab_ir1 = -1; ab_rk1 = -1;
    if (lat >= 0) exp_q.push_back(lat);
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      bus.in_valid   = (c == 0);
      bus.in_inverse = inv;
      bus.rnd_valid  = !in_win(c, rnd_at, rnd_len);
      bus.rk_valid   = !(in_win(c, rkf_at, rkf_len) || (c == rkn_at));
      bus.out_ready  = (hold == 0) || ((ov_first >= 0) && (c >= ov_first + hold));
`ifdef SMAESH_CTRL_ABORT_EN
      bus.abort      = (c == abort_at);
`endif
      if (c == rst_at) begin
        #1 rst_n = 1'b0;
        #1 check_eq("async_reset_outs", int'(outs), 13'h1000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        break;
      end
      @(negedge clk);
      stall = in_win(c, rnd_at, rnd_len) || in_win(c, rkf_at, rkf_len);
      busy  = (c >= 1) && (ov_first < 0) && !bus.out_valid;
      if (bus.rk_next) rk_cnt++;
      if (c == abort_at)     ab_ir0 = int'(bus.in_ready);
      if (c == abort_at + 1) begin ab_ir1 = int'(bus.in_ready); ab_rk1 = int'(bus.rk_next); end
      if (c >= 1 && c <= 80 && !bus.en_MC) begin
        mc0_cnt++;
        if (mc0_first < 0) mc0_first = c;
        mc0_last = c;
      end
      if (busy) begin
        if (bus.enable != !stall) en_err++;
        if (!bus.enable)  en_lo++;
        if (!bus.sbox_en) sb_lo++;
        if (bus.en_MC)    mc1_cnt++;
        if (bus.bypass_MC_inverse) begin
          byp_cnt++;
          if (byp_first < 0) byp_first = c;
          byp_last = c;
        end
        if (bus.en_toSB_inverse) tosb_cnt++;
        if (bus.en_loop)         loop_cnt++;
        if (bus.en_SB_inverse)   sbinv_cnt++;
        if (bus.en_loop_r0)      r0_cnt++;
        if (bus.in_ready)        rdy_busy++;
      end
      if (bus.out_valid) begin
        ov_cnt++;
        if (bus.in_ready || bus.enable) done_en++;
        if (ov_first < 0) begin
          ov_first = c;
          if (exp_q.size() == 0) check_eq("unexpected_out_valid", c, -1);
          else begin
            exp_lat = exp_q.pop_front();
            check_eq("out_valid_latency", c, exp_lat);
          end
        end
      end else if (ov_first >= 0) begin
        ir_after = int'(bus.in_ready);
        break;
      end
    end
    check_eq("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_inverse = 1'b0;
    bus.out_ready  = 1'b0;
    bus.rk_valid   = 1'b0;
    bus.rnd_valid  = 1'b0;
`ifdef SMAESH_CTRL_ABORT_EN
    bus.abort      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 check_eq("reset_outs", int'(outs), 13'h1000);
    rst_n = 1'b1;
    bus.rk_valid  = 1'b1;
    bus.rnd_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_in_ready", int'(bus.in_ready), 1);

    // Forward, no stalls
    run_txn(1'b0, -100, 0, -100, 0, -1, 0, -1, -1, 85, 200);
    check_eq("fwd_rk_next_pulses", rk_cnt, 11);
    check_eq("fwd_mc0_first", mc0_first, 73);
    check_eq("fwd_mc0_last", mc0_last, 80);
    check_eq("fwd_mc0_count", mc0_cnt, 8);
    check_eq("fwd_final_r0", r0_cnt, 4);
    check_eq("fwd_enable_pattern", en_err, 0);
    check_eq("fwd_sbox_en_low", sb_lo, 0);
    check_eq("fwd_inverse_sel", tosb_cnt + byp_cnt + loop_cnt + sbinv_cnt, 0);
    check_eq("fwd_in_ready_busy", rdy_busy, 0);
    check_eq("fwd_ov_cycles", ov_cnt, 1);
    check_eq("fwd_in_ready_after", ir_after, 1);

    // Randomness missing for 3 cycles in round 2 feed
    run_txn(1'b0, 18, 3, -100, 0, -1, 0, -1, -1, 88, 200);
    check_eq("rnd_enable_pattern", en_err, 0);
    check_eq("rnd_enable_low", en_lo, 3);
    check_eq("rnd_sbox_en_low", sb_lo, 3);
    check_eq("rnd_rk_next_pulses", rk_cnt, 11);

    // Key missing in a writeback cycle (no stall) and in two FINAL cycles (stall)
    run_txn(1'b0, -100, 0, 81, 2, 5, 0, -1, -1, 87, 200);
    check_eq("rk_enable_pattern", en_err, 0);
    check_eq("rk_sbox_en_low", sb_lo, 2);
    check_eq("rk_final_r0", r0_cnt, 6);

    // Inverse
    run_txn(1'b1, -100, 0, -100, 0, -1, 0, -1, -1, 85, 200);
    check_eq("inv_bypass_first", byp_first, 1);
    check_eq("inv_bypass_last", byp_last, 8);
    check_eq("inv_bypass_count", byp_cnt, 8);
    check_eq("inv_tosb_count", tosb_cnt, 80);
    check_eq("inv_en_mc_ones", mc1_cnt, 0);
    check_eq("inv_en_loop_count", loop_cnt, 40);
    check_eq("inv_en_sb_inv_count", sbinv_cnt, 40);
    check_eq("inv_rk_next_pulses", rk_cnt, 11);

    // Back-pressure in DONE for 5 cycles
    run_txn(1'b0, -100, 0, -100, 0, -1, 5, -1, -1, 85, 200);
    check_eq("hold_ov_cycles", ov_cnt, 6);
    check_eq("hold_frozen", done_en, 0);
    check_eq("hold_in_ready_busy", rdy_busy, 0);
    check_eq("hold_in_ready_after", ir_after, 1);

    // Reset mid-operation, then a fresh operation
    run_txn(1'b0, -100, 0, -100, 0, -1, 0, 40, -1, -1, 200);
    check_eq("rst_no_out_valid", ov_cnt, 0);
    check_eq("rst_rk_next_pulses", rk_cnt, 4);
    run_txn(1'b0, -100, 0, -100, 0, -1, 0, -1, -1, 85, 200);
    check_eq("post_rst_rk_next", rk_cnt, 11);

`ifdef SMAESH_CTRL_ABORT_EN
    run_txn(1'b0, -100, 0, -100, 0, -1, 0, -1, 30, -1, 100);
    check_eq("abort_in_ready_at", ab_ir0, 0);
    check_eq("abort_in_ready_next", ab_ir1, 1);
    check_eq("abort_rewind_pulse", ab_rk1, 1);
    check_eq("abort_no_out_valid", ov_cnt, 0);
    check_eq("abort_rk_next_pulses", rk_cnt, 4);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
